utils_mul_booth_iter: RTL

//  Iterative radix-4 Booth multiplier. Consumes one DW x DW operation per handshake and

---
 rtl/utils_mul_booth_iter.sv | 113 +++++++++++
 1 files changed

// File: rtl/utils_mul_booth_iter.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle, DW/2+1 steps per op.
// Handles signed and unsigned operands exactly by extending both operands by two bits.
module utils_mul_booth_iter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_p
);

  localparam int N  = DW / 2 + 1;
  localparam int EW = DW + 2;
  localparam int AW = 2 * DW + 2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [EW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [EW:0]     b_win;
  logic [2:0]      triple;
  logic [EW:0]     mag;
  logic            neg;
  logic [AW-1:0]   pp_ext;
  logic [AW-1:0]   pp_sh;
  logic [AW-1:0]   acc_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a raised out_valid holds with stable data until taken.
  assign in_ready = (state == IDLE);

  // b_win appends the implicit B[-1]=0 below the multiplier.
  assign b_win  = {b_ext, 1'b0};
  assign triple = 3'(b_win >> {cnt, 1'b0});

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (triple)
      3'b001, 3'b010: mag = {a_ext[EW-1], a_ext};
      3'b011:         mag = {a_ext, 1'b0};
      3'b100: begin
        mag = {a_ext, 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = {a_ext[EW-1], a_ext};
        neg = 1'b1;
      end
      default: ;
    endcase
    pp_ext   = {{(AW-EW-1){mag[EW]}}, mag};
    pp_sh    = pp_ext << {cnt, 1'b0};
    // Two's-complement negation with the +1 carried into the same add.
    acc_next = acc + (neg ? ~pp_sh : pp_sh) + AW'(neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_ext     <= '0;
      b_ext     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_ext <= in_signed ? {{2{in_a[DW-1]}}, in_a} : {2'b00, in_a};
            b_ext <= in_signed ? {{2{in_b[DW-1]}}, in_b} : {2'b00, in_b};
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            out_p     <= acc_next[2*DW-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
